reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback.sv | 81 ++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Writeback queue between result producers and the register-file write port.
// Results are held in a small FIFO and retired one per cycle unless the write port is held.
module reg_writeback #(
  parameter int DEPTH     = 4,
  parameter bit DROP_R0   = 1'b1,
  parameter int NUM_REGS  = 32,
  parameter int REG_WIDTH = 32,
  localparam int NRW      = $clog2(NUM_REGS),
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic [NRW-1:0]       in_rd,
  input  logic [REG_WIDTH-1:0] in_data,
  output logic                 in_ready,
  input  logic                 hold,
  output logic [NRW-1:0]       rd,
  output logic [REG_WIDTH-1:0] reg_in,
  output logic                 reg_write_en,
  output logic [NUM_REGS-1:0]  pending,
  output logic [CW-1:0]        count
);

  localparam int PW = $clog2(DEPTH);

  logic [NRW-1:0]       mem_rd   [DEPTH];
  logic [REG_WIDTH-1:0] mem_data [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        offs;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 empty;

  // Ready depends on occupancy only, so a full queue never bypasses a same-cycle pop.
  assign in_ready     = (count != CW'(DEPTH));
  assign empty        = (count == '0);
  assign drop         = DROP_R0 && (in_rd == '0);
  assign push         = in_valid && in_ready && !drop;
  assign reg_write_en = !empty && !hold;
  assign pop          = reg_write_en;
  assign rd           = empty ? '0 : mem_rd[rd_ptr];
  assign reg_in       = empty ? '0 : mem_data[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while the pointers mark them valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_rd[wr_ptr]   <= in_rd;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    pending = '0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rd_ptr;
      if ({1'b0, offs} < count) pending[mem_rd[i]] = 1'b1;
    end
  end

endmodule
